// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline hazard/stall controller.
//   state_e      : controller FSM states (RUN, MEM_WAIT, TIMEOUT)
//   WAIT_MAX_DEF : default maximum consecutive SRAM wait cycles
//   CNT_W_DEF    : default wait counter width
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  localparam int WAIT_MAX_DEF = 255;
  localparam int CNT_W_DEF    = 8;

  // Freeze vector bit order: {pc, if_id, id_exe, exe_mem, mem_wb}
  localparam logic [4:0] FRZ_ALL    = 5'b11111;
  localparam logic [4:0] FRZ_HAZARD = 5'b11000;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: handshake/control bundle between the pipeline and its controller.
//   Inputs to controller : hazard, branch_taken, mem_r_en, mem_w_en, sram_ready
//   Outputs              : five freezes, two flushes, timeout_err, stall_cnt, flush_cnt
//   master : pipeline side (drives hazard/branch/mem/sram status)
//   slave  : controller side (drives freezes, flushes, status, counters)
interface pipeline_ctrl_if;
  logic        hazard;
  logic        branch_taken;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        sram_ready;
  logic        pc_freeze;
  logic        if_id_freeze;
  logic        id_exe_freeze;
  logic        exe_mem_freeze;
  logic        mem_wb_freeze;
  logic        if_id_flush;
  logic        id_exe_flush;
  logic        timeout_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output hazard, branch_taken, mem_r_en, mem_w_en, sram_ready,
    input  pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, mem_wb_freeze,
    input  if_id_flush, id_exe_flush, timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard, branch_taken, mem_r_en, mem_w_en, sram_ready,
    output pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, mem_wb_freeze,
    output if_id_flush, id_exe_flush, timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_wait_timer.sv
// wait_timer: CNT_W-bit clear/increment counter for SRAM wait cycles.
//   clk, rst : clock, synchronous active-low reset
//   clr      : clear to zero (takes priority over inc)
//   inc      : increment; held at terminal count so it can never wrap
//   tc       : count equals WAIT_MAX
module wait_timer #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_W'(WAIT_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (inc && !tc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline stall/flush controller with SRAM wait handling.
//   clk, rst : clock, synchronous active-low reset
//   bus      : pipeline_ctrl_if.slave (hazard/branch/mem/sram in; freezes, flushes,
//              timeout_err, stall_cnt, flush_cnt out)
// Outputs are Mealy (state + current inputs). A branch resolved while the MEM
// stage is waiting is remembered and applied in the cycle the SRAM completes.
// Optional macro PIPE_PERF_CNT_EN enables saturating stall/flush counters;
// without it both counter ports read 0.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);
  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic [4:0] freeze;
  logic       if_id_flush, id_exe_flush;
  logic       tmr_clr, tmr_inc, tmr_tc;
  logic       resolve, br;
  logic       mem_req;

  assign mem_req = bus.mem_r_en | bus.mem_w_en;

  wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .inc (tmr_inc),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    freeze       = '0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;
    resolve      = 1'b0;
    br           = bus.branch_taken;
    if (!rst) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req && !bus.sram_ready) begin
            freeze  = FRZ_ALL;
            state_d = MEM_WAIT;
            tmr_inc = 1'b1;
            pend_d  = bus.branch_taken;
          end else begin
            resolve = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.sram_ready) begin
            freeze = FRZ_ALL;
            pend_d = pend_q | bus.branch_taken;
            if (tmr_tc) state_d = TIMEOUT;
            else        tmr_inc = 1'b1;
          end else begin
            resolve = 1'b1;
            br      = bus.branch_taken | pend_q;
            pend_d  = 1'b0;
            state_d = RUN;
            tmr_clr = 1'b1;
          end
        end
        TIMEOUT: freeze = FRZ_ALL;
        default: state_d = RUN;
      endcase
      // Branch outranks hazard: the flushed instructions make the hazard moot.
      if (resolve) begin
        if (br) begin
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
        end else if (bus.hazard) begin
          freeze       = FRZ_HAZARD;
          id_exe_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.pc_freeze      = freeze[4];
  assign bus.if_id_freeze   = freeze[3];
  assign bus.id_exe_freeze  = freeze[2];
  assign bus.exe_mem_freeze = freeze[1];
  assign bus.mem_wb_freeze  = freeze[0];
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_exe_flush   = id_exe_flush;
  assign bus.timeout_err    = rst & (state_q == TIMEOUT);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((|freeze) && (stall_cnt_q != '1))          stall_cnt_d = stall_cnt_q + 32'd1;
    if (rst && if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl. The stimulus process
// computes each cycle's expected outputs from a behavioural model and queues
// them; a monitor on the falling edge pops and compares against the DUT.
module tb_pipeline_ctrl;
  localparam int WM = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  frz;
    logic [1:0]  fl;
    logic        terr;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: mode of the controller described in plain terms.
  bit     m_wait = 0;   // MEM stage is waiting on SRAM
  bit     m_dead = 0;   // SRAM timed out; latched until reset
  bit     m_pend = 0;   // branch seen during wait, not yet applied
  int     m_waits = 0;  // wait cycles counted so far
  longint m_sc = 0;
  longint m_fc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit hz, input bit brt, input bit mr,
                     input bit mw, input bit rdy);
    exp_t e;
    bit req, b;
    @(posedge clk); #1;
    rst              = r;
    bus.hazard       = hz;
    bus.branch_taken = brt;
    bus.mem_r_en     = mr;
    bus.mem_w_en     = mw;
    bus.sram_ready   = rdy;
    req  = mr | mw;
    e.frz = '0; e.fl = '0; e.terr = 1'b0;
    if (!r) e.fl = 2'b11;
    else if (m_dead) begin
      e.frz = 5'b11111; e.terr = 1'b1;
    end else if (!rdy && (m_wait || req)) e.frz = 5'b11111;
    else begin
      b = brt | (m_wait & m_pend);
      if (b) e.fl = 2'b11;
      else if (hz) begin e.frz = 5'b11000; e.fl = 2'b01; end
    end
`ifdef PIPE_PERF_CNT_EN
    e.sc = 32'(m_sc); e.fc = 32'(m_fc);
`else
    e.sc = '0; e.fc = '0;
`endif
    sbq.push_back(e);
    // counters as they will stand after this edge
    if (!r) begin m_sc = 0; m_fc = 0; end
    else begin
      if (e.frz != 0 && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (e.fl[1] && m_fc < 64'hFFFF_FFFF) m_fc++;
    end
    // mode after this edge
    if (!r) begin
      m_wait = 0; m_dead = 0; m_waits = 0; m_pend = 0;
    end else if (!m_dead) begin
      if (m_wait) begin
        if (rdy) begin m_wait = 0; m_waits = 0; m_pend = 0; end
        else if (m_waits == WM) begin m_dead = 1; m_wait = 0; end
        else begin m_waits++; m_pend = m_pend | brt; end
      end else if (req && !rdy) begin
        m_wait = 1; m_waits = 1; m_pend = brt;
      end
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("freeze", {59'd0, bus.pc_freeze, bus.if_id_freeze, bus.id_exe_freeze,
                       bus.exe_mem_freeze, bus.mem_wb_freeze}, {59'd0, e.frz});
        chk("flush", {62'd0, bus.if_id_flush, bus.id_exe_flush}, {62'd0, e.fl});
        chk("timeout_err", {63'd0, bus.timeout_err}, {63'd0, e.terr});
        chk("stall_cnt", {32'd0, bus.stall_cnt}, {32'd0, e.sc});
        chk("flush_cnt", {32'd0, bus.flush_cnt}, {32'd0, e.fc});
      end
    end
  end

  initial begin
    bus.hazard = 0; bus.branch_taken = 0; bus.mem_r_en = 0;
    bus.mem_w_en = 0; bus.sram_ready = 0;
    // reset
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    // load, 3 wait cycles then ready
    repeat (3) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    // hazard and branch together
    cyc(1, 1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1);
    // store with 5-cycle wait, branch in cycle 2, applied at ready
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 1);
    cyc(1, 1, 0, 0, 0, 0);
    // timeout, sticky through sram_ready, cleared by reset
    repeat (7) cyc(1, 0, 0, 1, 0, 0);
    repeat (2) cyc(1, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // reset in the middle of a wait with a pending branch
    cyc(1, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    // 3 stalls then a branch
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) >= 4,
          $urandom_range(99) < 30,
          $urandom_range(99) < 25,
          $urandom_range(99) < 35,
          $urandom_range(99) < 20,
          $urandom_range(99) < 55);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
